fiapp_checker: RTL and testbench

- Downstream observer for the fiapp fault-injection target.
- Taps the same `a`/`enable` stimulus as the target, plus its three outputs `o1`/`o2`/`o3`.
- Runs a cycle-accurate golden model of the target and flags every cycle where an output diverges, e.g. after a VPI write to an internal flop.
- Accumulates per-output error counts and a first-error record, so injection campaigns can be scored without a testbench scoreboard.

---
 rtl/fiapp_checker.sv | 129 ++++++++++++
 tb/tb_fiapp_checker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fiapp_checker.sv
// fiapp_checker: cycle-accurate golden model of the fiapp target that watches
// the target's outputs and scores every divergence (per-output error counts,
// a sticky alarm and a first-error record).
module fiapp_checker #(
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned TS_W          = 16,
    parameter int unsigned STOP_ON_FAULT = 0,
    parameter int unsigned RESYNC        = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             enable,
    input  logic             o1,
    input  logic             o2,
    input  logic             o3,
    input  logic             arm,
    input  logic             clear,
    output logic [2:0]       mismatch,
    output logic             alarm,
    output logic [CNT_W-1:0] err_cnt1,
    output logic [CNT_W-1:0] err_cnt2,
    output logic [CNT_W-1:0] err_cnt3,
    output logic [TS_W-1:0]  first_err_time,
    output logic [2:0]       first_err_mask,
    output logic [1:0]       state
);

    // state | meaning
    // IDLE  | not checking; golden adopts target state from o1
    // CHECK | compare every cycle, count errors, advance timestamp
    // FAULT | frozen after first mismatch; golden keeps adopting o1
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam bit               FREE_RUN = (RESYNC == 0);
    localparam bit               STOP     = (STOP_ON_FAULT != 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [TS_W-1:0]  TS_ONE   = TS_W'(1);
    localparam logic [TS_W-1:0]  TS_MAX   = '1;

    state_t           cur_state;
    state_t           nxt_state;
    logic             g1, g2, g3;
    logic             seed;
    logic             checking;
    logic [2:0]       d;
    logic [TS_W-1:0]  ts;
    logic [CNT_W-1:0] cnt [3];

    assign checking = (cur_state == ST_CHECK);
    // Outside CHECK (and when re-synchronising) the golden model steps from the
    // observed target state, so arming in the middle of a run is valid.
    assign seed     = (checking && FREE_RUN) ? g1 : o1;
    assign d        = checking ? {o3 ^ g3, o2 ^ g2, o1 ^ g1} : 3'b000;

    assign state    = cur_state;
    assign err_cnt1 = cnt[0];
    assign err_cnt2 = cnt[1];
    assign err_cnt3 = cnt[2];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) cur_state <= ST_IDLE;
        else       cur_state <= nxt_state;
    end

    // Next-state logic; clear overrides arm.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_IDLE:  if (arm) nxt_state = ST_CHECK;
            ST_CHECK: begin
                if (!arm)                    nxt_state = ST_IDLE;
                else if (STOP && (d != 3'b0)) nxt_state = ST_FAULT;
            end
            ST_FAULT: nxt_state = ST_FAULT;
            default:  nxt_state = ST_IDLE;
        endcase
        if (clear) nxt_state = ST_IDLE;
    end

    // Golden model of the target's three flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            g1 <= 1'b0;
            g2 <= 1'b0;
            g3 <= 1'b0;
        end else begin
            g1 <= enable ? a : seed;
            g2 <= seed;
            g3 <= ~seed;
        end
    end

    // Check-cycle timestamp: held at zero outside CHECK, saturates.
    always_ff @(posedge clk) begin
        if (reset || !checking) ts <= '0;
        else if (ts != TS_MAX)  ts <= ts + TS_ONE;
    end

    // Compare result, saturating error counters and first-error record.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            mismatch       <= 3'b000;
            alarm          <= 1'b0;
            first_err_time <= '0;
            first_err_mask <= 3'b000;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            mismatch <= d;
            if (checking) begin
                for (int i = 0; i < 3; i++) begin
                    if (d[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_ONE;
                end
                if ((d != 3'b000) && !alarm) begin
                    alarm          <= 1'b1;
                    first_err_time <= ts;
                    first_err_mask <= d;
                end
            end
        end
    end

endmodule

// File: tb/tb_fiapp_checker.sv
// Bench for fiapp_checker: a behavioural fiapp target with a q1 flip input
// drives four checker configurations (resync, free-run, stop-on-fault,
// narrow saturating counters).
module tb_fiapp_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, a, enable, arm, clear, flip;
    logic q1, q2, q3;

    // Target model; flip inverts the value captured into q1 (fault injection).
    always @(posedge clk) begin
        if (reset) begin
            q1 <= 1'b0; q2 <= 1'b0; q3 <= 1'b0;
        end else begin
            q1 <= (enable ? a : q1) ^ flip;
            q2 <= q1;
            q3 <= ~q1;
        end
    end

    logic [2:0]  mm_rs, mm_fr, mm_st, mm_sa;
    logic        al_rs, al_fr, al_st, al_sa;
    logic [7:0]  c1_rs, c2_rs, c3_rs, c1_fr, c2_fr, c3_fr, c1_st, c2_st, c3_st;
    logic [1:0]  c1_sa, c2_sa, c3_sa;
    logic [15:0] ft_rs, ft_fr, ft_st, ft_sa;
    logic [2:0]  fm_rs, fm_fr, fm_st, fm_sa;
    logic [1:0]  st_rs, st_fr, st_st, st_sa;

    fiapp_checker #(.CNT_W(8), .TS_W(16), .STOP_ON_FAULT(0), .RESYNC(1)) u_rs (
        .clk(clk), .reset(reset), .a(a), .enable(enable), .o1(q1), .o2(q2), .o3(q3),
        .arm(arm), .clear(clear), .mismatch(mm_rs), .alarm(al_rs),
        .err_cnt1(c1_rs), .err_cnt2(c2_rs), .err_cnt3(c3_rs),
        .first_err_time(ft_rs), .first_err_mask(fm_rs), .state(st_rs));

    fiapp_checker #(.CNT_W(8), .TS_W(16), .STOP_ON_FAULT(0), .RESYNC(0)) u_fr (
        .clk(clk), .reset(reset), .a(a), .enable(enable), .o1(q1), .o2(q2), .o3(q3),
        .arm(arm), .clear(clear), .mismatch(mm_fr), .alarm(al_fr),
        .err_cnt1(c1_fr), .err_cnt2(c2_fr), .err_cnt3(c3_fr),
        .first_err_time(ft_fr), .first_err_mask(fm_fr), .state(st_fr));

    fiapp_checker #(.CNT_W(8), .TS_W(16), .STOP_ON_FAULT(1), .RESYNC(1)) u_st (
        .clk(clk), .reset(reset), .a(a), .enable(enable), .o1(q1), .o2(q2), .o3(q3),
        .arm(arm), .clear(clear), .mismatch(mm_st), .alarm(al_st),
        .err_cnt1(c1_st), .err_cnt2(c2_st), .err_cnt3(c3_st),
        .first_err_time(ft_st), .first_err_mask(fm_st), .state(st_st));

    fiapp_checker #(.CNT_W(2), .TS_W(16), .STOP_ON_FAULT(0), .RESYNC(0)) u_sa (
        .clk(clk), .reset(reset), .a(a), .enable(enable), .o1(q1), .o2(q2), .o3(q3),
        .arm(arm), .clear(clear), .mismatch(mm_sa), .alarm(al_sa),
        .err_cnt1(c1_sa), .err_cnt2(c2_sa), .err_cnt3(c3_sa),
        .first_err_time(ft_sa), .first_err_mask(fm_sa), .state(st_sa));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic ia, input logic ie,
                        input logic iarm, input logic iclr, input logic ifl);
        reset = r; a = ia; enable = ie; arm = iarm; clear = iclr; flip = ifl;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst, a, en, arm, clr, flp;
        logic [2:0] mm;
        logic [1:0] st;
        logic       al;
        logic [7:0] c1;
    } vec_t;

    function automatic vec_t v(input logic r, input logic ia, input logic ie,
                               input logic iarm, input logic iclr, input logic ifl,
                               input logic [2:0] emm, input logic [1:0] est,
                               input logic eal, input logic [7:0] ec1);
        vec_t t;
        t.rst = r; t.a = ia; t.en = ie; t.arm = iarm; t.clr = iclr; t.flp = ifl;
        t.mm = emm; t.st = est; t.al = eal; t.c1 = ec1;
        return t;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [11:0] pat;
        pat = 12'b1011_0100_1101;

        // Reset, clean 12-cycle run, then a single q1 inversion at ts=5 (resync).
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 3'b000, 2'd0, 0, 8'd0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 3'b000, 2'd0, 0, 8'd0));
        tbl.push_back(v(0, 1, 1, 1, 0, 0, 3'b000, 2'd1, 0, 8'd0));
        for (int k = 0; k < 12; k++)
            tbl.push_back(v(0, pat[11-k], 1, 1, 0, 0, 3'b000, 2'd1, 0, 8'd0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 3'b000, 2'd0, 0, 8'd0));
        tbl.push_back(v(0, 0, 1, 1, 0, 0, 3'b000, 2'd1, 0, 8'd0)); // entry
        tbl.push_back(v(0, 1, 1, 1, 0, 0, 3'b000, 2'd1, 0, 8'd0)); // ts0
        tbl.push_back(v(0, 1, 1, 1, 0, 0, 3'b000, 2'd1, 0, 8'd0)); // ts1
        tbl.push_back(v(0, 0, 1, 1, 0, 0, 3'b000, 2'd1, 0, 8'd0)); // ts2
        tbl.push_back(v(0, 1, 1, 1, 0, 0, 3'b000, 2'd1, 0, 8'd0)); // ts3
        tbl.push_back(v(0, 0, 1, 1, 0, 1, 3'b000, 2'd1, 0, 8'd0)); // ts4, flip
        tbl.push_back(v(0, 1, 1, 1, 0, 0, 3'b001, 2'd1, 1, 8'd1)); // ts5 mismatch
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 3'b000, 2'd1, 1, 8'd1));
        tbl.push_back(v(0, 1, 1, 1, 0, 0, 3'b000, 2'd1, 1, 8'd1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].a, tbl[i].en, tbl[i].arm, tbl[i].clr, tbl[i].flp);
            chk($sformatf("row%0d mismatch", i), 32'(mm_rs), 32'(tbl[i].mm));
            chk($sformatf("row%0d state", i),    32'(st_rs), 32'(tbl[i].st));
            chk($sformatf("row%0d alarm", i),    32'(al_rs), 32'(tbl[i].al));
            chk($sformatf("row%0d err_cnt1", i), 32'(c1_rs), 32'(tbl[i].c1));
        end
        chk("rs first_err_time", 32'(ft_rs), 32'd5);
        chk("rs first_err_mask", 32'(fm_rs), 32'd1);
        chk("rs err_cnt2",       32'(c2_rs), 32'd0);
        chk("rs err_cnt3",       32'(c3_rs), 32'd0);

        // Free-running golden, enable=0, q1 inverted at ts=3; also saturation.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0); // entry
        step(0, 1, 0, 1, 0, 0); // ts0
        step(0, 0, 0, 1, 0, 0); // ts1
        step(0, 1, 0, 1, 0, 1); // ts2, flip
        step(0, 1, 0, 1, 0, 0); // ts3
        chk("fr mismatch ts3", 32'(mm_fr), 32'b001);
        step(0, 0, 0, 1, 0, 0); // ts4
        chk("fr mismatch ts4", 32'(mm_fr), 32'b111);
        step(0, 1, 0, 1, 0, 0); // ts5
        step(0, 0, 0, 1, 0, 0); // ts6
        chk("fr err_cnt1", 32'(c1_fr), 32'd4);
        chk("fr err_cnt2", 32'(c2_fr), 32'd3);
        chk("fr err_cnt3", 32'(c3_fr), 32'd3);
        chk("fr first_err_mask", 32'(fm_fr), 32'b001);
        chk("fr first_err_time", 32'(ft_fr), 32'd3);
        step(0, 1, 0, 1, 0, 0); // ts7
        step(0, 0, 0, 1, 0, 0); // ts8
        chk("sa err_cnt1 sat", 32'(c1_sa), 32'd3);
        chk("sa err_cnt2 sat", 32'(c2_sa), 32'd3);
        chk("sa err_cnt3 sat", 32'(c3_sa), 32'd3);
        chk("sa alarm",        32'(al_sa), 32'd1);
        chk("sa state",        32'(st_sa), 32'd1);
        chk("fr err_cnt1 6",   32'(c1_fr), 32'd6);

        // Stop-on-fault: inversion at ts=2, later faults ignored, then clear.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0); // entry
        step(0, 0, 1, 1, 0, 0); // ts0
        step(0, 1, 1, 1, 0, 1); // ts1, flip
        step(0, 0, 1, 1, 0, 0); // ts2 mismatch
        chk("st state fault",  32'(st_st), 32'd2);
        chk("st mismatch",     32'(mm_st), 32'b001);
        chk("st err_cnt1",     32'(c1_st), 32'd1);
        step(0, 1, 1, 1, 0, 1);
        chk("st mismatch frozen", 32'(mm_st), 32'b000);
        step(0, 0, 1, 1, 0, 1);
        step(0, 1, 1, 0, 0, 0);
        chk("st state holds",  32'(st_st), 32'd2);
        chk("st err_cnt1 frozen", 32'(c1_st), 32'd1);
        chk("st first_err_time", 32'(ft_st), 32'd2);
        step(0, 0, 1, 1, 1, 0); // clear
        chk("st clear state",  32'(st_st), 32'd0);
        chk("st clear cnt1",   32'(c1_st), 32'd0);
        chk("st clear alarm",  32'(al_st), 32'd0);
        chk("st clear time",   32'(ft_st), 32'd0);

        // clear+arm together, re-entry carries ts=0, then reset mid-CHECK.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 1, 0); // clear and arm
        chk("rs clear+arm state", 32'(st_rs), 32'd0);
        step(0, 0, 1, 1, 0, 1); // entry, flip
        chk("rs reentry state", 32'(st_rs), 32'd1);
        step(0, 1, 1, 1, 0, 1); // ts0 mismatch, flip again
        chk("rs reentry ts0 time", 32'(ft_rs), 32'd0);
        chk("rs reentry alarm",    32'(al_rs), 32'd1);
        step(0, 0, 1, 1, 0, 0); // ts1 mismatch
        chk("rs err_cnt1 two",  32'(c1_rs), 32'd2);
        step(1, 1, 1, 1, 0, 0); // reset mid-CHECK
        chk("rs rst mismatch",  32'(mm_rs), 32'd0);
        chk("rs rst alarm",     32'(al_rs), 32'd0);
        chk("rs rst err_cnt1",  32'(c1_rs), 32'd0);
        chk("rs rst time",      32'(ft_rs), 32'd0);
        chk("rs rst mask",      32'(fm_rs), 32'd0);
        chk("rs rst state",     32'(st_rs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
